// File: rtl/icache_set_assoc.sv
// Two-way set-associative instruction cache with LRU replacement, multi-cycle
// flush and saturating hit/miss counters. Memory returns one full line per request.
module icache_set_assoc #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned WORD_W         = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned SETS           = 4
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_flush,
  input  logic                                      i_read_enable,
  input  logic [ADDR_W-1:0]                         i_address,
  output logic                                      o_read_ready,
  output logic [WORD_W-1:0]                         o_instruction,
  input  logic                                      i_memory_read_ready,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]          i_memory_data,
  output logic [ADDR_W-$clog2(WORDS_PER_LINE)-1:0]  o_memory_address,
  output logic                                      o_memory_read_enable,
  output logic [15:0]                               o_hit_count,
  output logic [15:0]                               o_miss_count
);

  localparam int unsigned WB     = $clog2(WORDS_PER_LINE);
  localparam int unsigned SB     = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - SB - WB;
  localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;

  typedef enum logic [1:0] {StReady, StMiss, StFlush} state_e;

  state_e              r_state, w_state_next;
  logic [SETS-1:0]     r_valid0, r_valid1;
  logic [SETS-1:0]     r_lru;          // way to evict next when both ways are valid
  logic [LINE_W-1:0]   r_data [2][SETS];
  logic [TAG_W-1:0]    r_tag  [2][SETS];
  logic [SB-1:0]       r_flush_cnt;
  logic                r_flush_pend;   // flush seen while a fill is outstanding
  logic                r_read_ready;
  logic [WORD_W-1:0]   r_instruction;
  logic [15:0]         r_hit_count, r_miss_count;

  logic [TAG_W-1:0]    w_tag;
  logic [SB-1:0]       w_set;
  logic [WB-1:0]       w_word;
  logic                w_hit0, w_hit1, w_hit, w_victim;
  logic [LINE_W-1:0]   w_hit_line;
  logic [WORD_W-1:0]   w_hit_word, w_fill_word;
  logic                w_hit_ev, w_miss_ev, w_fill_ev;

  assign w_tag  = i_address[ADDR_W-1 -: TAG_W];
  assign w_set  = i_address[WB +: SB];
  assign w_word = i_address[WB-1:0];

  assign w_hit0     = r_valid0[w_set] && (r_tag[0][w_set] == w_tag);
  assign w_hit1     = r_valid1[w_set] && (r_tag[1][w_set] == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  // Prefer an empty way (way 0 first); otherwise evict the least recently used.
  assign w_victim   = !r_valid0[w_set] ? 1'b0 : (!r_valid1[w_set] ? 1'b1 : r_lru[w_set]);
  assign w_hit_line = w_hit1 ? r_data[1][w_set] : r_data[0][w_set];
  assign w_hit_word  = w_hit_line[int'(w_word) * WORD_W +: WORD_W];
  assign w_fill_word = i_memory_data[int'(w_word) * WORD_W +: WORD_W];

  assign o_memory_address     = i_address[ADDR_W-1:WB];
  assign o_memory_read_enable = (r_state == StMiss);
  assign o_read_ready         = r_read_ready;
  assign o_instruction        = r_instruction;
  assign o_hit_count          = r_hit_count;
  assign o_miss_count         = r_miss_count;

  // Next-state decode and per-cycle lookup/fill events.
  always_comb begin
    w_state_next = r_state;
    w_hit_ev     = 1'b0;
    w_miss_ev    = 1'b0;
    w_fill_ev    = 1'b0;
    unique case (r_state)
      StReady: begin
        if (i_flush) begin
          w_state_next = StFlush;
        end else if (i_read_enable) begin
          if (w_hit) begin
            w_hit_ev = 1'b1;
          end else begin
            w_miss_ev    = 1'b1;
            w_state_next = StMiss;
          end
        end
      end
      StMiss: begin
        if (i_memory_read_ready) begin
          w_fill_ev    = 1'b1;
          w_state_next = (r_flush_pend || i_flush) ? StFlush : StReady;
        end
      end
      StFlush: begin
        if (r_flush_cnt == SB'(SETS - 1)) w_state_next = StReady;
      end
      default: w_state_next = StReady;
    endcase
  end

  // Control state, valid/LRU bits, output registers and counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StReady;
      r_valid0      <= '0;
      r_valid1      <= '0;
      r_lru         <= '0;
      r_flush_cnt   <= '0;
      r_flush_pend  <= 1'b0;
      r_read_ready  <= 1'b0;
      r_instruction <= '0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_read_ready <= w_hit_ev || w_fill_ev;
      r_flush_pend <= w_fill_ev ? 1'b0 : (r_flush_pend || ((r_state == StMiss) && i_flush));
      r_flush_cnt  <= (r_state == StFlush) ? r_flush_cnt + 1'b1 : '0;
      if (w_hit_ev) begin
        r_instruction <= w_hit_word;
        r_lru[w_set]  <= ~w_hit1;
        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_miss_ev && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
      if (w_fill_ev) begin
        r_instruction <= w_fill_word;
        r_lru[w_set]  <= ~w_victim;
        if (w_victim) r_valid1[w_set] <= 1'b1;
        else          r_valid0[w_set] <= 1'b1;
      end
      if (r_state == StFlush) begin
        r_valid0[r_flush_cnt] <= 1'b0;
        r_valid1[r_flush_cnt] <= 1'b0;
        r_lru[r_flush_cnt]    <= 1'b0;
      end
    end
  end

  // Line data and tag storage; only meaningful where the valid bit is set.
  always_ff @(posedge i_clk) begin
    if (w_fill_ev) begin
      r_data[w_victim][w_set] <= i_memory_data;
      r_tag[w_victim][w_set]  <= w_tag;
    end
  end

endmodule
